// File: rtl/quiz_round_ctrl_pkg.sv
// Shared types and defaults for the two-player quiz round controller.
package quiz_round_ctrl_pkg;

   localparam int PAD_W         = 9;
   localparam int NUM_Q_DEF     = 9;
   localparam int TIMEOUT_DEF   = 1000;
   localparam int SHOW_CYC_DEF  = 200;
   localparam int SCORE_MAX_DEF = 9;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ASK  = 2'd1,
      ST_SHOW = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_L    = 2'b01,
      WIN_R    = 2'b10
   } winner_t;

   // Outcome of one cycle of pad arbitration.
   typedef struct packed {
      logic any;        // at least one unlocked press this cycle
      logic tie;        // both pads pressed together
      logic right;      // grant went to the right pad
      logic ok;         // granted key matches the answer
      logic both_lock;  // both players locked once this cycle settles
   } grant_t;

   function automatic logic [3:0] sat_inc(input logic [3:0] v, input logic [3:0] cap);
      return (v >= cap) ? v : v + 4'd1;
   endfunction

endpackage

// File: rtl/quiz_round_ctrl_press_edge_det.sv
// Registers one answer pad and flags a fresh press (rising edge of any key).
module press_edge_det
   import quiz_round_ctrl_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [PAD_W-1:0] pad_i,
   output logic             press_o,
   output logic [PAD_W-1:0] key_o
);

   logic [PAD_W-1:0] pad_q;
   logic             any_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pad_q <= '0;
         any_q <= 1'b0;
      end else begin
         pad_q <= pad_i;
         any_q <= |pad_q;
      end
   end

   // A change of key while another is still held is not a new press.
   assign press_o = (|pad_q) & ~any_q;
   assign key_o   = pad_q;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Two-player quiz round sequencer: question stepping, pad arbitration, scoring, timeout.
//  state | meaning
//  IDLE  | after reset, waiting for start
//  ASK   | question open, presses judged, timeout running
//  SHOW  | result held for SHOW_CYC cycles
//  DONE  | game finished, scores held, waiting for start
module quiz_round_ctrl
   import quiz_round_ctrl_pkg::*;
#(
   parameter int NUM_Q     = NUM_Q_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF,
   parameter int SHOW_CYC  = SHOW_CYC_DEF,
   parameter int SCORE_MAX = SCORE_MAX_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             bank_sel_i,
   input  logic [PAD_W-1:0] joy_left_i,
   input  logic [PAD_W-1:0] joy_right_i,
   input  logic [PAD_W-1:0] answer_key_i,
   output logic             bank_o,
   output logic [3:0]       q_index_o,
   output logic             asking_o,
   output logic [3:0]       score_left_o,
   output logic [3:0]       score_right_o,
   output logic             lock_left_o,
   output logic             lock_right_o,
   output logic             result_vld_o,
   output logic [1:0]       winner_o,
   output logic             game_over_o
);

   localparam int TMR_W  = $clog2(TIMEOUT + 1);
   localparam int HOLD_W = $clog2(SHOW_CYC + 1);
   localparam logic [TMR_W-1:0]  TMR_LOAD  = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(SHOW_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [3:0]        LAST_Q    = 4'(NUM_Q - 1);
   localparam logic [3:0]        SCORE_CAP = 4'(SCORE_MAX);

   state_t            state_q, state_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [3:0]        q_index_q, q_index_d;
   logic              bank_q, bank_d;
   logic [3:0]        score_l_q, score_l_d;
   logic [3:0]        score_r_q, score_r_d;
   logic              lock_l_q, lock_l_d;
   logic              lock_r_q, lock_r_d;
   logic              rr_q, rr_d;
   winner_t           winner_q, winner_d;
   logic              rvld_q, rvld_d;

   logic              press_l, press_r;
   logic [PAD_W-1:0]  key_l, key_r;
   logic              in_ask, vld_l, vld_r, wrong, to_show;
   logic [PAD_W-1:0]  grant_key;
   grant_t            grant;

   press_edge_det u_pad_l (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_i   (joy_left_i),
      .press_o (press_l),
      .key_o   (key_l)
   );

   press_edge_det u_pad_r (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pad_i   (joy_right_i),
      .press_o (press_r),
      .key_o   (key_r)
   );

   assign in_ask = (state_q == ST_ASK);

   // Round-robin pointer only decides true ties; a dropped press never queues.
   always_comb begin
      grant           = '0;
      vld_l           = in_ask & press_l & ~lock_l_q;
      vld_r           = in_ask & press_r & ~lock_r_q;
      grant.any       = vld_l | vld_r;
      grant.tie       = vld_l & vld_r;
      grant.right     = grant.tie ? rr_q : vld_r;
      grant_key       = grant.right ? key_r : key_l;
      grant.ok        = grant.any & (grant_key == answer_key_i);
      wrong           = grant.any & ~grant.ok;
      grant.both_lock = (lock_l_q | (wrong & ~grant.right)) &
                        (lock_r_q | (wrong &  grant.right));
      to_show         = in_ask & (grant.ok | grant.both_lock | (timer_q == '0));
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_DONE: if (start_i) state_d = ST_ASK;
         ST_ASK:           if (to_show) state_d = ST_SHOW;
         ST_SHOW: begin
            if (hold_q == '0) state_d = (q_index_q == LAST_Q) ? ST_DONE : ST_ASK;
         end
         default:          state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      asking_o    = (state_q == ST_ASK);
      game_over_o = (state_q == ST_DONE);
   end

   always_comb begin
      timer_d   = timer_q;
      hold_d    = hold_q;
      q_index_d = q_index_q;
      bank_d    = bank_q;
      score_l_d = score_l_q;
      score_r_d = score_r_q;
      lock_l_d  = lock_l_q;
      lock_r_d  = lock_r_q;
      rr_d      = rr_q;
      winner_d  = winner_q;
      rvld_d    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               q_index_d = '0;
               bank_d    = bank_sel_i;
               score_l_d = '0;
               score_r_d = '0;
               lock_l_d  = 1'b0;
               lock_r_d  = 1'b0;
               timer_d   = TMR_LOAD;
            end
         end
         ST_ASK: begin
            if (timer_q != '0) timer_d = timer_q - TMR_ONE;
            if (grant.tie) rr_d = ~rr_q;
            if (wrong) begin
               if (grant.right) lock_r_d = 1'b1;
               else             lock_l_d = 1'b1;
            end
            if (grant.ok) begin
               if (grant.right) score_r_d = sat_inc(score_r_q, SCORE_CAP);
               else             score_l_d = sat_inc(score_l_q, SCORE_CAP);
            end
            if (to_show) begin
               winner_d = grant.ok ? (grant.right ? WIN_R : WIN_L) : WIN_NONE;
               rvld_d   = 1'b1;
               hold_d   = HOLD_LOAD;
            end
         end
         ST_SHOW: begin
            if (hold_q != '0) begin
               hold_d = hold_q - HOLD_ONE;
            end else if (q_index_q != LAST_Q) begin
               q_index_d = q_index_q + 4'd1;
               lock_l_d  = 1'b0;
               lock_r_d  = 1'b0;
               timer_d   = TMR_LOAD;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         timer_q   <= '0;
         hold_q    <= '0;
         q_index_q <= '0;
         bank_q    <= 1'b0;
         score_l_q <= '0;
         score_r_q <= '0;
         lock_l_q  <= 1'b0;
         lock_r_q  <= 1'b0;
         rr_q      <= 1'b0;
         winner_q  <= WIN_NONE;
         rvld_q    <= 1'b0;
      end else begin
         timer_q   <= timer_d;
         hold_q    <= hold_d;
         q_index_q <= q_index_d;
         bank_q    <= bank_d;
         score_l_q <= score_l_d;
         score_r_q <= score_r_d;
         lock_l_q  <= lock_l_d;
         lock_r_q  <= lock_r_d;
         rr_q      <= rr_d;
         winner_q  <= winner_d;
         rvld_q    <= rvld_d;
      end
   end

   assign bank_o        = bank_q;
   assign q_index_o     = q_index_q;
   assign score_left_o  = score_l_q;
   assign score_right_o = score_r_q;
   assign lock_left_o   = lock_l_q;
   assign lock_right_o  = lock_r_q;
   assign result_vld_o  = rvld_q;
   assign winner_o      = winner_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Directed-plus-random bench for quiz_round_ctrl against a game-level reference model.
module tb_quiz_round_ctrl;

   // Scores clear at every game start, so showing saturation needs more questions than SCORE_MAX.
   localparam int NQ   = 12;
   localparam int TO   = 1000;
   localparam int SC   = 200;
   localparam int SMAX = 9;

   logic       clk = 1'b0;
   logic       rst, start, bank_sel;
   logic [8:0] joy_l, joy_r, akey;
   logic       bank_o, asking_o, lock_left_o, lock_right_o, result_vld_o, game_over_o;
   logic [3:0] q_index_o, score_left_o, score_right_o;
   logic [1:0] winner_o;

   logic [8:0] tab [2][16];
   int         errors = 0;
   int         checks = 0;

   logic       m_bank, m_ll, m_lr, m_rr, m_ask, m_over;
   int         m_q, m_sl, m_sr;
   logic [1:0] m_win;

   always #5 clk = ~clk;

   assign akey = tab[bank_o][q_index_o];

   quiz_round_ctrl #(.NUM_Q(NQ), .TIMEOUT(TO), .SHOW_CYC(SC), .SCORE_MAX(SMAX)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .start_i       (start),
      .bank_sel_i    (bank_sel),
      .joy_left_i    (joy_l),
      .joy_right_i   (joy_r),
      .answer_key_i  (akey),
      .bank_o        (bank_o),
      .q_index_o     (q_index_o),
      .asking_o      (asking_o),
      .score_left_o  (score_left_o),
      .score_right_o (score_right_o),
      .lock_left_o   (lock_left_o),
      .lock_right_o  (lock_right_o),
      .result_vld_o  (result_vld_o),
      .winner_o      (winner_o),
      .game_over_o   (game_over_o)
   );

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, required finish before time limit");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ctx);
      chk({ctx, " bank"},        16'(bank_o),        16'(m_bank));
      chk({ctx, " q_index"},     16'(q_index_o),     16'(m_q));
      chk({ctx, " asking"},      16'(asking_o),      16'(m_ask));
      chk({ctx, " score_left"},  16'(score_left_o),  16'(m_sl));
      chk({ctx, " score_right"}, 16'(score_right_o), 16'(m_sr));
      chk({ctx, " lock_left"},   16'(lock_left_o),   16'(m_ll));
      chk({ctx, " lock_right"},  16'(lock_right_o),  16'(m_lr));
      chk({ctx, " winner"},      16'(winner_o),      16'(m_win));
      chk({ctx, " game_over"},   16'(game_over_o),   16'(m_over));
   endtask

   function automatic logic [8:0] wrong_key(input logic [8:0] k);
      logic [8:0] v;
      v = k;
      while (v == k) v = 9'($urandom_range(511, 1));
      return v;
   endfunction

   // Game rules applied to one press event (0 = that pad did not press).
   task automatic model_press(input logic [8:0] l, input logic [8:0] r, output logic ended);
      logic vl, vr, gr;
      logic [8:0] k;
      ended = 1'b0;
      vl = (l != 0) && !m_ll;
      vr = (r != 0) && !m_lr;
      if (vl || vr) begin
         if (vl && vr) begin
            gr   = m_rr;
            m_rr = !m_rr;
         end else begin
            gr = vr;
         end
         k = gr ? r : l;
         if (k == tab[m_bank][m_q]) begin
            if (gr) begin
               if (m_sr < SMAX) m_sr++;
               m_win = 2'b10;
            end else begin
               if (m_sl < SMAX) m_sl++;
               m_win = 2'b01;
            end
            ended = 1'b1;
         end else begin
            if (gr) m_lr = 1'b1;
            else    m_ll = 1'b1;
            if (m_ll && m_lr) begin
               m_win = 2'b00;
               ended = 1'b1;
            end
         end
      end
      if (ended) m_ask = 1'b0;
   endtask

   task automatic press(input string tag, input logic [8:0] l, input logic [8:0] r);
      logic ended;
      joy_l = l;
      joy_r = r;
      tick(1);
      check_all({tag, " edge1"});
      chk({tag, " edge1 result_vld"}, 16'(result_vld_o), 16'd0);
      tick(1);
      model_press(l, r, ended);
      check_all(tag);
      chk({tag, " result_vld"}, 16'(result_vld_o), 16'(ended));
      joy_l = '0;
      joy_r = '0;
      if (!ended) tick(1);
   endtask

   task automatic show_phase(input logic [8:0] hold_l);
      tick(1);
      chk("show pulse end", 16'(result_vld_o), 16'd0);
      chk("show winner hold", 16'(winner_o), 16'(m_win));
      joy_l = hold_l;
      tick(SC - 2);
      chk("show last asking", 16'(asking_o), 16'd0);
      chk("show last q_index", 16'(q_index_o), 16'(m_q));
      tick(1);
      if (m_q == NQ - 1) begin
         m_over = 1'b1;
      end else begin
         m_q++;
         m_ll  = 1'b0;
         m_lr  = 1'b0;
         m_ask = 1'b1;
      end
      check_all("advance");
      chk("advance result_vld", 16'(result_vld_o), 16'd0);
   endtask

   task automatic model_start(input logic b);
      m_bank = b;
      m_q    = 0;
      m_sl   = 0;
      m_sr   = 0;
      m_ll   = 1'b0;
      m_lr   = 1'b0;
      m_ask  = 1'b1;
      m_over = 1'b0;
   endtask

   task automatic start_game(input logic b);
      bank_sel = b;
      start    = 1'b1;
      tick(1);
      start    = 1'b0;
      model_start(b);
      check_all("start");
   endtask

   task automatic timeout_q(input string tag);
      tick(TO - 1);
      chk({tag, " still asking"}, 16'(asking_o), 16'd1);
      chk({tag, " no result yet"}, 16'(result_vld_o), 16'd0);
      tick(1);
      m_win = 2'b00;
      m_ask = 1'b0;
      check_all(tag);
      chk({tag, " result_vld"}, 16'(result_vld_o), 16'd1);
   endtask

   task automatic model_reset();
      m_bank = 1'b0;
      m_q    = 0;
      m_sl   = 0;
      m_sr   = 0;
      m_ll   = 1'b0;
      m_lr   = 1'b0;
      m_rr   = 1'b0;
      m_ask  = 1'b0;
      m_over = 1'b0;
      m_win  = 2'b00;
   endtask

   initial begin
      logic [8:0] k;
      int act;
      for (int b = 0; b < 2; b++)
         for (int q = 0; q < 16; q++)
            tab[b][q] = 9'b1 << $urandom_range(8, 0);
      tab[0][0] = 9'h008;

      rst = 1'b1; start = 1'b0; bank_sel = 1'b0; joy_l = '0; joy_r = '0;
      model_reset();
      tick(3);
      check_all("reset");
      chk("reset result_vld", 16'(result_vld_o), 16'd0);
      rst = 1'b0;
      tick(2);
      check_all("idle");

      // Game A on bank 0; bank_sel toggled afterwards must not reach bank.
      start_game(1'b0);
      bank_sel = 1'b1;
      press("q0 left correct", tab[0][0], 9'h000);
      show_phase(9'h000);

      start = 1'b1;
      tick(1);
      start = 1'b0;
      check_all("start ignored in ASK");
      press("q1 tie", tab[0][1], tab[0][1]);
      show_phase(9'h000);
      press("q2 tie", tab[0][2], tab[0][2]);
      show_phase(9'h000);

      press("q3 left wrong", wrong_key(tab[0][3]), 9'h000);
      press("q3 locked left", tab[0][3], 9'h000);
      press("q3 right wrong", 9'h000, wrong_key(tab[0][3]));
      show_phase(9'h000);

      press("q4 tie wrong grant", wrong_key(tab[0][4]), tab[0][4]);
      press("q4 right repress", 9'h000, tab[0][4]);
      show_phase(tab[0][5]);

      timeout_q("q5 timeout held key");
      show_phase(9'h000);

      while (!m_over) begin
         k   = tab[m_bank][m_q];
         act = $urandom_range(3, 0);
         case (act)
            0: press("rand left", k, 9'h000);
            1: press("rand right", 9'h000, k);
            2: press("rand tie", k, k);
            default: begin
               press("rand left wrong", wrong_key(k), 9'h000);
               press("rand right after lock", 9'h000, k);
            end
         endcase
         show_phase(9'h000);
      end
      tick(5);
      check_all("done hold");
      chk("done result_vld", 16'(result_vld_o), 16'd0);

      // Game B: left answers everything, score saturates; start held through DONE.
      start_game(1'b1);
      bank_sel = 1'b0;
      for (int i = 0; i < NQ; i++) begin
         press("sat left", tab[1][m_q], 9'h000);
         if (i == NQ - 1) start = 1'b1;
         show_phase(9'h000);
      end
      chk("saturated score", 16'(score_left_o), 16'(SMAX));
      tick(1);
      model_start(1'b0);
      start = 1'b0;
      check_all("immediate restart");

      // Game C: reset in the middle of a question.
      for (int i = 0; i < 3; i++) begin
         press("pre-reset left", tab[0][m_q], 9'h000);
         show_phase(9'h000);
      end
      chk("pre-reset score", 16'(score_left_o), 16'd3);
      rst = 1'b1;
      tick(1);
      model_reset();
      check_all("mid reset");
      chk("mid reset result_vld", 16'(result_vld_o), 16'd0);
      rst = 1'b0;
      tick(1);
      check_all("after reset idle");
      start_game(1'b1);
      press("post-reset tie", tab[1][0], tab[1][0]);
      show_phase(9'h000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
